// File: rtl/counter_60.sv
// ---------------------------------------------------------------------------
// counter_60 -- two-digit packed-BCD modulo-60 counter (00..59).
//
// Used for the seconds and minutes stages of a digital clock. The count
// advances once per enabled rising clock edge and wraps from 59 to 00. The
// carry output is combinational so a following stage can use it directly as
// its enable and step on the same clock edge as the wrap.
//
// Ports:
//   clk        in   1  rising-edge clock
//   cr         in   1  asynchronous active-high clear, forces data to 8'h00
//   en         in   1  count enable, sampled on the rising clk edge
//   up_siganl  out  1  carry to next stage: en & (data == 8'h59) & ~cr
//   data       out  8  count, packed BCD: [7:4] tens (0..5), [3:0] units (0..9)
// ---------------------------------------------------------------------------
module counter_60 (
    input  logic       clk,
    input  logic       cr,
    input  logic       en,
    output logic       up_siganl,
    output logic [7:0] data
);

    localparam logic [3:0] UnitsMax = 4'd9;
    localparam logic [3:0] TensMax  = 4'd5;
    localparam logic [7:0] CountMax = 8'h59;
    localparam logic [7:0] CountMin = 8'h00;

    logic [7:0] data_q;
    logic [7:0] data_d;

    logic [3:0] units;
    logic [3:0] tens;
    logic       units_legal;
    logic       tens_legal;
    logic       state_legal;
    logic       units_wrap;
    logic       at_max;

    assign units = data_q[3:0];
    assign tens  = data_q[7:4];

    // Any non-BCD units digit or a tens digit above 5 is outside the
    // counting sequence and is recovered to 00 on the next enabled edge.
    assign units_legal = (units <= UnitsMax);
    assign tens_legal  = (tens <= TensMax);
    assign state_legal = units_legal & tens_legal;

    assign units_wrap = (units == UnitsMax);
    assign at_max     = (data_q == CountMax);

    always_comb begin
        data_d = data_q;
        if (en) begin
            if (!state_legal) begin
                data_d = CountMin;
            end else if (units_wrap) begin
                data_d[3:0] = 4'd0;
                data_d[7:4] = (tens == TensMax) ? 4'd0 : tens + 4'd1;
            end else begin
                data_d[3:0] = units + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            data_q <= CountMin;
        end else begin
            data_q <= data_d;
        end
    end

    // Carry is deliberately unregistered: the next stage samples it as its
    // enable on the same edge that performs the 59 -> 00 wrap here.
    assign up_siganl = en & at_max & ~cr;
    assign data      = data_q;

endmodule

// File: tb/tb_counter_60.sv
module tb_counter_60;

    logic       clk;
    logic       cr;
    logic       en;
    logic       up_lo;
    logic [7:0] data_lo;
    logic       up_hi;
    logic [7:0] data_hi;

    int checks = 0;
    int errors = 0;

    // Low stage is the device under test; the high stage is cascaded from it.
    counter_60 dut (
        .clk       (clk),
        .cr        (cr),
        .en        (en),
        .up_siganl (up_lo),
        .data      (data_lo)
    );

    counter_60 dut_hi (
        .clk       (clk),
        .cr        (cr),
        .en        (up_lo),
        .up_siganl (up_hi),
        .data      (data_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         sel;       // 0: low stage, 1: high stage
        logic [7:0] exp_data;
        logic       exp_up;
    } exp_t;

    exp_t sb_q[$];
    event push_ev;

    function automatic logic [7:0] bcd(input int v);
        int m;
        m = v % 60;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic expect_out(input string name, input int sel, input logic [7:0] d,
                              input logic u);
        exp_t e;
        e.name     = name;
        e.sel      = sel;
        e.exp_data = d;
        e.exp_up   = u;
        sb_q.push_back(e);
        -> push_ev;
        #0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations and compares them with the live outputs.
    initial begin
        exp_t       e;
        logic [7:0] act_d;
        logic       act_u;
        forever begin
            @(push_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act_d = (e.sel == 0) ? data_lo : data_hi;
                act_u = (e.sel == 0) ? up_lo : up_hi;
                checks++;
                if (act_d !== e.exp_data || act_u !== e.exp_up) begin
                    errors++;
                    $display("FAIL %s: data=%h up=%b, required data=%h up=%b",
                             e.name, act_d, act_u, e.exp_data, e.exp_up);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int carries;

        cr = 1'b1;
        en = 1'b1;
        #2;
        expect_out("reset", 0, 8'h00, 1'b0);
        step(2);
        expect_out("reset_held_edges", 0, 8'h00, 1'b0);

        // Clear while running.
        cr = 1'b0;
        step(23);
        expect_out("count_to_23", 0, 8'h23, 1'b0);
        #2;
        cr = 1'b1;
        #1;
        expect_out("async_clear", 0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_out("clear_hold", 0, 8'h00, 1'b0);
        end

        // Free run across a full cycle.
        cr = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (i == 10)      expect_out("rollover_09_10", 0, 8'h10, 1'b0);
            else if (i == 50) expect_out("rollover_49_50", 0, 8'h50, 1'b0);
            else if (i == 60) expect_out("wrap_59_00", 0, 8'h00, 1'b0);
            else              expect_out("free_run", 0, bcd(i), (i == 59));
        end

        // Carry timing and carry count over 120 enabled edges.
        step(59);
        expect_out("carry_before_edge", 0, 8'h59, 1'b1);
        step(1);
        expect_out("carry_after_edge", 0, 8'h00, 1'b0);
        carries = 0;
        for (int i = 0; i < 120; i++) begin
            if (up_lo === 1'b1) carries++;
            step(1);
        end
        checks++;
        if (carries != 2) begin
            errors++;
            $display("FAIL carry_count: saw %0d carry cycles, required 2", carries);
        end
        expect_out("after_120", 0, 8'h00, 1'b0);

        // Enable hold at 59.
        step(59);
        expect_out("at_59", 0, 8'h59, 1'b1);
        en = 1'b0;
        #1;
        expect_out("hold_carry_low", 0, 8'h59, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            expect_out("hold_59", 0, 8'h59, 1'b0);
        end
        en = 1'b1;
        #1;
        expect_out("hold_release_carry", 0, 8'h59, 1'b1);
        step(1);
        expect_out("hold_release_wrap", 0, 8'h00, 1'b0);

        // Recovery from an illegal state.
        step(59);
        en = 1'b0;
        force dut.data_q = 8'h7A;
        #1;
        expect_out("illegal_forced", 0, 8'h7A, 1'b0);
        en = 1'b1;
        #1;
        expect_out("illegal_no_carry", 0, 8'h7A, 1'b0);
        release dut.data_q;
        step(1);
        expect_out("illegal_recover", 0, 8'h00, 1'b0);
        step(1);
        expect_out("after_recover", 0, 8'h01, 1'b0);

        // Cascade of two stages.
        cr = 1'b1;
        #1;
        expect_out("cascade_clear_lo", 0, 8'h00, 1'b0);
        expect_out("cascade_clear_hi", 1, 8'h00, 1'b0);
        cr = 1'b0;
        step(60);
        expect_out("cascade_60_lo", 0, 8'h00, 1'b0);
        expect_out("cascade_60_hi", 1, 8'h01, 1'b0);
        step(3540);
        expect_out("cascade_3600_lo", 0, 8'h00, 1'b0);
        expect_out("cascade_3600_hi", 1, 8'h00, 1'b0);
        step(61);
        expect_out("cascade_3661_lo", 0, 8'h01, 1'b0);
        expect_out("cascade_3661_hi", 1, 8'h01, 1'b0);

        #5;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
